// File: rtl/canny_stage_ctrl.sv
// Frame-level sequencer for the Canny datapath.
// It runs each enabled stage (gauss, sobel, nms, hyst) in turn. For each stage it
// pulses stage_start, raster-scans pixel coordinates over pix_valid/pix_ready, and
// then waits for stage_idle before moving to the next enabled stage.
// Ports:
//   clk, reset (sync, active-low)      clock / reset
//   frame_start, stage_en[3:0], abort  frame control from the top level
//   stage_idle, pix_ready              status from the selected stage pipeline
//   stage_sel, stage_start             active stage index and its start pulse
//   pix_valid, pix_x, pix_y, pix_border  coordinate stream to the stage/line buffers
//   frame_busy, frame_done, aborted    frame status
//   frame_cycles[31:0]                 cycle count of the last completed frame
module canny_stage_ctrl #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned COORD_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [3:0]         stage_en,
    input  logic               abort,
    input  logic               stage_idle,
    input  logic               pix_ready,
    output logic [1:0]         stage_sel,
    output logic               stage_start,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_border,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               aborted,
    output logic [31:0]        frame_cycles
);

    localparam int unsigned CNT_W = 32;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, START, SCAN, DRAIN, DONE} state_t;

    state_t           state;
    logic [3:0]       en_q;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cycle_cnt_inc;
    logic [2:0]       first_stage;   // {found, index}
    logic [2:0]       next_stage;    // {found, index}

    // Lowest set bit of mask at or above position lo, as {found, index}.
    function automatic logic [2:0] find_stage(input logic [3:0] mask, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic on_border(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    endfunction

    assign first_stage   = find_stage(stage_en, 3'd0);
    assign next_stage    = find_stage(en_q, {1'b0, stage_sel} + 3'd1);
    assign cycle_cnt_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    // Sequencer; every output is updated together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            en_q         <= '0;
            cycle_cnt    <= '0;
            stage_sel    <= '0;
            stage_start  <= 1'b0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_border   <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            aborted      <= 1'b0;
            frame_cycles <= '0;
        end else begin
            stage_start <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;
            if (state != IDLE) cycle_cnt <= cycle_cnt_inc;

            // Abort overrides every transition, including the one into IDLE from DONE.
            if (state != IDLE && abort) begin
                state      <= IDLE;
                pix_valid  <= 1'b0;
                frame_busy <= 1'b0;
                aborted    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (frame_start) begin
                            en_q       <= stage_en;
                            cycle_cnt  <= '0;
                            frame_busy <= 1'b1;
                            if (first_stage[2]) begin
                                state       <= START;
                                stage_sel   <= first_stage[1:0];
                                stage_start <= 1'b1;
                                pix_x       <= '0;
                                pix_y       <= '0;
                                pix_border  <= 1'b1;  // origin is always on the edge
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    START: begin
                        state     <= SCAN;
                        pix_valid <= 1'b1;
                    end
                    SCAN: begin
                        if (pix_ready) begin
                            if (pix_x == X_LAST) begin
                                if (pix_y == Y_LAST) begin
                                    state     <= DRAIN;
                                    pix_valid <= 1'b0;
                                end else begin
                                    pix_x      <= '0;
                                    pix_y      <= pix_y + COORD_W'(1);
                                    pix_border <= on_border('0, pix_y + COORD_W'(1));
                                end
                            end else begin
                                pix_x      <= pix_x + COORD_W'(1);
                                pix_border <= on_border(pix_x + COORD_W'(1), pix_y);
                            end
                        end
                    end
                    DRAIN: begin
                        if (stage_idle) begin
                            if (next_stage[2]) begin
                                state       <= START;
                                stage_sel   <= next_stage[1:0];
                                stage_start <= 1'b1;
                                pix_x       <= '0;
                                pix_y       <= '0;
                                pix_border  <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state        <= IDLE;
                        frame_done   <= 1'b1;
                        frame_busy   <= 1'b0;
                        frame_cycles <= cycle_cnt_inc;  // includes the DONE cycle
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/canny_stage_ctrl.md
# canny_stage_ctrl

Frame-level sequencer for the Canny edge-detection datapath. On a frame request it runs the enabled stages (Gaussian smooth, Sobel gradient, non-maximum suppression, hysteresis) one at a time. For each stage it issues a start pulse, raster-scans pixel coordinates over a valid/ready handshake, and waits for the stage pipeline to drain before moving on. It sits between the top-level frame control and the shared stage datapaths / line-buffer address logic.

## Interface
Parameters:
- IMG_W, 64, image width in pixels (≥ 2)
- IMG_H, 64, image height in pixels (≥ 2)
- COORD_W, 8, width of pixel coordinate outputs (2^COORD_W ≥ max(IMG_W, IMG_H))

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- frame_start  in  1  request a frame; sampled only in IDLE
- stage_en  in  4  stage enable mask: bit0 gauss, bit1 sobel, bit2 nms, bit3 hyst; latched at accepted frame_start
- abort  in  1  abandon the current frame; ignored in IDLE
- stage_idle  in  1  selected stage pipeline empty
- pix_ready  in  1  selected stage accepts the current coordinate
- stage_sel  out  2  index of the active stage (0..3)
- stage_start  out  1  one-cycle pulse at the start of each stage
- pix_valid  out  1  pix_x/pix_y valid
- pix_x  out  COORD_W  column
- pix_y  out  COORD_W  row
- pix_border  out  1  the current coordinate is on the image edge
- frame_busy  out  1  controller not in IDLE
- frame_done  out  1  one-cycle pulse when the frame completes normally
- aborted  out  1  one-cycle pulse when a frame was abandoned
- frame_cycles  out  32  cycle count of the last completed frame

## Operation
- States: IDLE, START, SCAN, DRAIN, DONE.
- IDLE:
  - On frame_start=1, latch stage_en into en_q and clear the cycle counter.
  - If en_q≠0, go to START with stage_sel set to the lowest set bit.
  - If en_q=0, go directly to DONE.
- START:
  - stage_start=1 for exactly this cycle.
  - Load x=0, y=0; go to SCAN.
- SCAN:
  - pix_valid=1. Coordinates advance only on pix_valid&pix_ready.
  - Advance rule: x increments; at x=IMG_W-1, x wraps to 0 and y increments.
  - When (IMG_W-1, IMG_H-1) is accepted, go to DRAIN.
  - pix_x, pix_y and pix_valid are held stable while pix_ready=0.
- DRAIN:
  - pix_valid=0. Wait for stage_idle=1.
  - Then go to START with the next higher enabled stage, or to DONE if none remains.
  - stage_idle is ignored in every state except DRAIN.
- DONE:
  - frame_done=1 for one cycle.
  - frame_cycles is loaded with the counter value; return to IDLE.
- pix_border = (x==0) | (x==IMG_W-1) | (y==0) | (y==IMG_H-1), evaluated on the current coordinate.
- Cycle counter:
  - Counts every cycle with state≠IDLE, including the DONE cycle.
  - Saturates at 2^32-1.
  - frame_cycles holds its value until the next completed frame.
- Abort:
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - aborted=1 for that one cycle; frame_done is not pulsed and frame_cycles is unchanged.
  - If abort and the transition to DONE coincide, abort wins.
- frame_start while busy is ignored and not queued. stage_en changes during a frame have no effect.

## Timing
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - stage_sel=0, stage_start=0, pix_valid=0, pix_x=0, pix_y=0, pix_border=0.
  - frame_busy=0, frame_done=0, aborted=0, frame_cycles=0.
  - Reset mid-frame behaves identically, with no frame_done or aborted pulse.
- All outputs are registered. frame_busy=1 from the cycle after frame_start is accepted until the cycle after DONE.
- Per-stage latency with pix_ready tied to 1 and stage_idle already 1:
  - START 1 cycle + SCAN IMG_W*IMG_H cycles + DRAIN 1 cycle.
- Frame latency:
  - N enabled stages: frame_cycles = N*(IMG_W*IMG_H+2)+1.
  - Mask 0: frame_done pulses in the 2nd cycle after frame_start, with frame_cycles=1.
- stage_sel is stable from START through DRAIN of a stage and changes only on entry to START.

## Test plan
- IMG_W=IMG_H=4, stage_en=4'b1111, pix_ready=1, stage_idle=1 -> four stage_start pulses with stage_sel 0,1,2,3; 16 coordinates per stage in raster order; frame_done pulse; frame_cycles=73.
- stage_en=4'b0101 -> stages 0 and 2 only; frame_cycles=37. stage_en=0 -> frame_done two cycles after frame_start, frame_cycles=1, pix_valid never asserted.
- Random pix_ready backpressure (~50%) -> no coordinate skipped or duplicated; outputs held while stalled; pix_border=1 for exactly 12 of 16 coordinates.
- stage_idle held 0 for 10 cycles in DRAIN -> no next stage_start until stage_idle=1; frame_cycles grows by exactly 10 versus the baseline.
- abort asserted at coordinate (2,1) of stage 1 -> IDLE next cycle; aborted pulses; no frame_done; frame_cycles keeps its prior value; a new frame_start then runs normally.
- reset=0 mid-SCAN -> all outputs at reset values next cycle; frame_start during busy is ignored (a single frame_done only).
